// File: rtl/spi_slave_counter_rx_pkg.sv
// Shared types and constants for the SPI counter-frame receiver.
package spi_rx_pkg;

    // Receiver states: WAIT_IDLE guards against joining a frame already in flight.
    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        RX_LSB,
        RX_MSB,
        DONE
    } state_t;

    localparam int BYTE_W            = 8;
    localparam int DEFAULT_MAX_COUNT = 9999;
    localparam int DEFAULT_VAL_W     = 14;

    // True while bits are being shifted into the receive register.
    function automatic logic frame_active(input state_t s);
        return (s == RX_LSB) || (s == RX_MSB);
    endfunction

endpackage

// File: rtl/spi_slave_counter_rx_sync_edge.sv
// Synchronises SCLK, MOSI and SS_n into the clk domain and derives edge strobes.
// Every synchroniser flop resets to the bus idle level (SCLK=0, SS_n=1, MOSI=0).
module spi_rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic ss_n_i,
    output logic mosi_s,
    output logic ss_n_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_rise,
    output logic ss_fall
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
    logic                   sclk_del_q,  sclk_del_d;
    logic                   ss_del_q,    ss_del_d;
    logic                   sclk_s;

    // Next value of each synchroniser chain plus the one-cycle delayed copies for edge detection.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   ss_n_i};
        sclk_del_d  = sclk_sync_q[SYNC_STAGES-1];
        ss_del_d    = ss_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay registers, reset to the idle bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_del_q  <= 1'b0;
            ss_del_q    <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_del_q  <= sclk_del_d;
            ss_del_q    <= ss_del_d;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_n_s    = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_del_q;
    assign sclk_fall = ~sclk_s & sclk_del_q;
    assign ss_rise   = ss_n_s & ~ss_del_q;
    assign ss_fall   = ~ss_n_s & ss_del_q;

endmodule

// File: rtl/spi_slave_counter_rx.sv
// SPI mode-0 slave receiving a two-byte counter frame (LSB byte first, each byte MSB first).
// Optional echo of the last published value on MISO: define SPI_RX_MISO_ECHO_EN.
module spi_slave_counter_rx
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_COUNT   = DEFAULT_MAX_COUNT,
    parameter int VAL_W       = DEFAULT_VAL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic             SS_n,
    output logic             MISO,
    output logic [VAL_W-1:0] count_value,
    output logic             count_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [1:0] SETTLE_CYCLES = 2'(SYNC_STAGES);

    logic mosi_s, ss_n_s, sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_rx_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_i    (SCLK),
        .mosi_i    (MOSI),
        .ss_n_i    (SS_n),
        .mosi_s    (mosi_s),
        .ss_n_s    (ss_n_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall)
    );

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [BYTE_W-1:0]   lsb_buf_q, lsb_buf_d;
    logic                msb_done_q, msb_done_d;
    logic                overrun_q, overrun_d;
    logic [1:0]          settle_q, settle_d;
    logic [VAL_W-1:0]    count_value_q, count_value_d;
    logic                count_valid_q, count_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;

    logic                byte_done;
    logic [13:0]         rx_value;
    logic                rx_ok;

    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_value  = {shreg_q[5:0], lsb_buf_q};
    assign rx_ok     = (shreg_q[7:6] == 2'b00) && (32'(rx_value) <= MAX_COUNT);

    // Frame FSM next state: shifting, byte reassembly, range check and error detection.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        lsb_buf_d     = lsb_buf_q;
        msb_done_d    = 1'b0;
        overrun_d     = overrun_q;
        settle_d      = settle_q;
        count_value_d = count_value_q;
        count_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        busy_d        = busy_q;

        if (msb_done_q) begin
            if (rx_ok) begin
                count_value_d = VAL_W'(rx_value);
                count_valid_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end

        case (state_q)
            WAIT_IDLE: begin
                if (settle_q != SETTLE_CYCLES) begin
                    settle_d = settle_q + 2'd1;
                end else if (ss_n_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    state_d   = RX_LSB;
                    bit_cnt_d = 3'd0;
                    shreg_d   = '0;
                    overrun_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            RX_LSB, RX_MSB: begin
                if (ss_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    bit_cnt_d   = 3'd0;
                    shreg_d     = '0;
                    busy_d      = 1'b0;
                end else if (sclk_rise) begin
                    shreg_d   = {shreg_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if (state_q == RX_LSB) begin
                            lsb_buf_d = {shreg_q[6:0], mosi_s};
                            state_d   = RX_MSB;
                        end else begin
                            msb_done_d = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    if (overrun_q) begin
                        frame_err_d = 1'b1;
                    end
                    overrun_d = 1'b0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end else if (sclk_rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Frame FSM registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= '0;
            lsb_buf_q     <= '0;
            msb_done_q    <= 1'b0;
            overrun_q     <= 1'b0;
            settle_q      <= 2'd0;
            count_value_q <= '0;
            count_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            lsb_buf_q     <= lsb_buf_d;
            msb_done_q    <= msb_done_d;
            overrun_q     <= overrun_d;
            settle_q      <= settle_d;
            count_value_q <= count_value_d;
            count_valid_q <= count_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign count_value = count_value_q;
    assign count_valid = count_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

`ifdef SPI_RX_MISO_ECHO_EN
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic              tx_skip_q, tx_skip_d;

    // Echo shifter: load low byte at frame start, high byte at the first byte wrap, shift on SCLK falls.
    always_comb begin
        tx_d      = tx_q;
        tx_skip_d = tx_skip_q;
        if (state_q == IDLE && ss_fall) begin
            tx_d      = count_value_q[BYTE_W-1:0];
            tx_skip_d = 1'b0;
        end else if (state_q == RX_LSB && byte_done && !ss_rise) begin
            tx_d      = BYTE_W'(count_value_q >> BYTE_W);
            tx_skip_d = 1'b1;
        end else if (sclk_fall) begin
            if (tx_skip_q) begin
                tx_skip_d = 1'b0;
            end else begin
                tx_d = {tx_q[BYTE_W-2:0], 1'b0};
            end
        end
    end

    // Echo shifter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= '0;
            tx_skip_q <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            tx_skip_q <= tx_skip_d;
        end
    end

    assign MISO = ss_n_s ? 1'bz : tx_q[BYTE_W-1];
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign MISO = ss_n_s ? 1'bz : 1'b0;
`endif

endmodule
